// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, counter sizing and divide-by-zero constants for the radix-2 divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Sliced down to DATA_WIDTH by the user; wide enough for the largest legal width.
    localparam logic [63:0] DBZ_QUOTIENT = '1;
    localparam logic        DBZ_FLAG     = 1'b1;

endpackage

// File: rtl/radix2_div_ctrl.sv
// rtl/radix2_div_ctrl.sv - IDLE/CALC/DONE sequencer for the radix-2 divider
module radix2_div_ctrl
    import div_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic div_zero_i,
    input  logic calc_last_i,
    output logic accept_o,
    output logic busy_o,
    output logic done_o
);

    div_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE and DONE share the same acceptance behaviour, which gives back-to-back starts.
    always_comb begin
        state_d  = state_q;
        accept_o = 1'b0;
        case (state_q)
            CALC: begin
                if (calc_last_i) begin
                    state_d = DONE;
                end
            end
            default: begin
                if (start_i) begin
                    accept_o = 1'b1;
                    state_d  = div_zero_i ? DONE : CALC;
                end else begin
                    state_d  = IDLE;
                end
            end
        endcase
    end

    assign busy_o = (state_q == CALC);
    assign done_o = (state_q == DONE);

endmodule

// File: rtl/radix2_divider.sv
// rtl/radix2_divider.sv - restoring radix-2 divider datapath; define RADIX2_DIVIDER_SIGNED_EN for signed_op support
module radix2_divider
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Operand1,
    input  logic [DATA_WIDTH-1:0] Operand2,
    input  logic                  signed_op,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_W    = CW'(DATA_WIDTH);

    logic          accept, calc_last, div_zero;
    logic [W-1:0]  div_q, div_d, q_q, q_d, r_q, r_d;
    logic [W-1:0]  quot_q, quot_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;
    logic [W-1:0]  a_mag, b_mag;
    logic [W:0]    trial, diff;
    logic [W-1:0]  iter_q, iter_r;

    assign div_zero = (Operand2 == '0);

`ifdef RADIX2_DIVIDER_SIGNED_EN
    logic sfix_q, sfix_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic a_neg, b_neg;

    assign a_neg     = signed_op & Operand1[W-1];
    assign b_neg     = signed_op & Operand2[W-1];
    assign a_mag     = a_neg ? -Operand1 : Operand1;
    assign b_mag     = b_neg ? -Operand2 : Operand2;
    // Signed runs spend one more CALC cycle (counter == W) applying the result signs.
    assign calc_last = sfix_q ? (cnt_q == CNT_W) : (cnt_q == CNT_LAST);
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_mag            = Operand1;
    assign b_mag            = Operand2;
    assign calc_last        = (cnt_q == CNT_LAST);
`endif

    // The partial remainder stays below the divisor, so bit W of diff is a clean borrow.
    assign trial  = {r_q, q_q[W-1]};
    assign diff   = trial - {1'b0, div_q};
    assign iter_r = diff[W] ? trial[W-1:0] : diff[W-1:0];
    assign iter_q = {q_q[W-2:0], ~diff[W]};

    radix2_div_ctrl u_ctrl (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .start_i     (start),
        .div_zero_i  (div_zero),
        .calc_last_i (calc_last),
        .accept_o    (accept),
        .busy_o      (busy),
        .done_o      (done)
    );

    always_comb begin
        div_d  = div_q;
        q_d    = q_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
`ifdef RADIX2_DIVIDER_SIGNED_EN
        sfix_d = sfix_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
`endif
        if (accept) begin
            div_d = b_mag;
            q_d   = a_mag;
            r_d   = '0;
            cnt_d = '0;
`ifdef RADIX2_DIVIDER_SIGNED_EN
            sfix_d = signed_op;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
`endif
            if (div_zero) begin
                quot_d = DBZ_QUOTIENT[W-1:0];
                rem_d  = Operand1;
                dbz_d  = DBZ_FLAG;
            end
        end else if (busy) begin
            if (cnt_q != CNT_W) begin
                q_d   = iter_q;
                r_d   = iter_r;
                cnt_d = cnt_q + CW'(1);
            end
            if (calc_last) begin
                quot_d = iter_q;
                rem_d  = iter_r;
                dbz_d  = 1'b0;
`ifdef RADIX2_DIVIDER_SIGNED_EN
                if (sfix_q) begin
                    quot_d = qneg_q ? -q_q : q_q;
                    rem_d  = rneg_q ? -r_q : r_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            q_q    <= q_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

`ifdef RADIX2_DIVIDER_SIGNED_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sfix_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            sfix_q <= sfix_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`endif

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_radix2_divider.sv
// tb/tb_radix2_divider.sv - randomized and directed bench for radix2_divider (DATA_WIDTH=32)
module tb_radix2_divider;

    logic        CLK, RST, start, signed_op;
    logic [31:0] Operand1, Operand2, quotient, remainder;
    logic        busy, done, div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef RADIX2_DIVIDER_SIGNED_EN
    localparam bit SIGNED_MODEL = 1'b1;
`else
    localparam bit SIGNED_MODEL = 1'b0;
`endif

    radix2_divider #(.DATA_WIDTH(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .Operand1    (Operand1),
        .Operand2    (Operand2),
        .signed_op   (signed_op),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Arithmetic reference: latency counts the accepting edge as cycle 1.
    task automatic ref_div(input logic [31:0] a, b, input logic s,
                           output logic [31:0] q, r, output logic z, output int lat);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 1;
        end else if (SIGNED_MODEL && s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0; lat = 34;
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = 33;
        end
    endtask

    // Waits for done after an accept edge that has just passed; lat = -1 on timeout.
    task automatic wait_done(output int lat, output logic [31:0] q, r, output logic z);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (done) begin
                lat = i;
                break;
            end
            @(posedge CLK);
        end
        q = quotient; r = remainder; z = div_by_zero;
    endtask

    task automatic run_op(input logic [31:0] a, b, input logic s,
                          output int lat, output logic [31:0] q, r, output logic z);
        @(negedge CLK);
        Operand1 = a; Operand2 = b; signed_op = s; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        wait_done(lat, q, r, z);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_cmp += 5;
        if (quotient !== 32'd0)  begin n_fail++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        RST = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] q, r; logic z;
        run_op(32'd100, 32'd7, 1'b0, lat, q, r, z);
        n_cmp += 4;
        if (lat !== 33)    begin n_fail++; $display("FAIL basic_latency got=%0d exp=33", lat); end
        if (q !== 32'd14)  begin n_fail++; $display("FAIL basic_quotient got=%0d exp=14", q); end
        if (r !== 32'd2)   begin n_fail++; $display("FAIL basic_remainder got=%0d exp=2", r); end
        if (z !== 1'b0)    begin n_fail++; $display("FAIL basic_dbz got=%b exp=0", z); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] q, r; logic z;
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, q, r, z);
        n_cmp += 3;
        if (lat !== 33)           begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=33", lat); end
        if (q !== 32'hFFFF_FFFF)  begin n_fail++; $display("FAIL b2b_first_quotient got=%h exp=ffffffff", q); end
        if (r !== 32'd0)          begin n_fail++; $display("FAIL b2b_first_remainder got=%h exp=0", r); end
        Operand1 = 32'd5; Operand2 = 32'd9; signed_op = 1'b0; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle busy got=%b exp=1", busy); end
        @(posedge CLK);
        wait_done(lat, q, r, z);
        lat = lat + 1;
        n_cmp += 3;
        if (lat !== 33)   begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
        if (q !== 32'd0)  begin n_fail++; $display("FAIL b2b_second_quotient got=%0d exp=0", q); end
        if (r !== 32'd5)  begin n_fail++; $display("FAIL b2b_second_remainder got=%0d exp=5", r); end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] q, r; logic z;
        run_op(32'd42, 32'd0, 1'b0, lat, q, r, z);
        n_cmp += 4;
        if (lat !== 1)            begin n_fail++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
        if (q !== 32'hFFFF_FFFF)  begin n_fail++; $display("FAIL dbz_quotient got=%h exp=ffffffff", q); end
        if (r !== 32'd42)         begin n_fail++; $display("FAIL dbz_remainder got=%0d exp=42", r); end
        if (z !== 1'b1)           begin n_fail++; $display("FAIL dbz_flag got=%b exp=1", z); end
        run_op(32'd8, 32'd2, 1'b0, lat, q, r, z);
        n_cmp += 2;
        if (z !== 1'b0)   begin n_fail++; $display("FAIL dbz_clear got=%b exp=0", z); end
        if (q !== 32'd4)  begin n_fail++; $display("FAIL dbz_next_quotient got=%0d exp=4", q); end
    endtask

    task automatic test_ignore_start();
        int lat; logic [31:0] q, r;
        @(negedge CLK);
        Operand1 = 32'd100; Operand2 = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (done) begin lat = i; break; end
            if (i == 10) begin
                Operand1 = 32'd50; Operand2 = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK);
        end
        q = quotient; r = remainder;
        n_cmp += 3;
        if (lat !== 33)   begin n_fail++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
        if (q !== 32'd14) begin n_fail++; $display("FAIL ignore_quotient got=%0d exp=14", q); end
        if (r !== 32'd2)  begin n_fail++; $display("FAIL ignore_remainder got=%0d exp=2", r); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] q, r; logic z;
        @(negedge CLK);
        Operand1 = 32'd100; Operand2 = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        for (int i = 1; i < 15; i++) @(negedge CLK);
        RST = 1'b0;
        #1;
        n_cmp += 4;
        if (quotient !== 32'd0)  begin n_fail++; $display("FAIL abort_quotient got=%h exp=0", quotient); end
        if (remainder !== 32'd0) begin n_fail++; $display("FAIL abort_remainder got=%h exp=0", remainder); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (done !== 1'b0)       begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        Operand1 = 32'd9; Operand2 = 32'd3; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        wait_done(lat, q, r, z);
        n_cmp += 3;
        if (lat !== 33)   begin n_fail++; $display("FAIL abort_fresh_latency got=%0d exp=33", lat); end
        if (q !== 32'd3)  begin n_fail++; $display("FAIL abort_fresh_quotient got=%0d exp=3", q); end
        if (r !== 32'd0)  begin n_fail++; $display("FAIL abort_fresh_remainder got=%0d exp=0", r); end
    endtask

`ifdef RADIX2_DIVIDER_SIGNED_EN
    task automatic test_signed();
        int lat; logic [31:0] q, r; logic z;
        run_op(-32'sd7, 32'd2, 1'b1, lat, q, r, z);
        n_cmp += 3;
        if (lat !== 34)          begin n_fail++; $display("FAIL signed_latency got=%0d exp=34", lat); end
        if (q !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL signed_quotient got=%h exp=fffffffd", q); end
        if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL signed_remainder got=%h exp=ffffffff", r); end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, q, r, z);
        n_cmp += 4;
        if (lat !== 34)          begin n_fail++; $display("FAIL minneg_latency got=%0d exp=34", lat); end
        if (q !== 32'h8000_0000) begin n_fail++; $display("FAIL minneg_quotient got=%h exp=80000000", q); end
        if (r !== 32'd0)         begin n_fail++; $display("FAIL minneg_remainder got=%h exp=0", r); end
        if (z !== 1'b0)          begin n_fail++; $display("FAIL minneg_dbz got=%b exp=0", z); end
    endtask
`endif

    task automatic test_random();
        int lat, elat; logic [31:0] a, b, q, r, eq, er; logic s, z, ez;
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2, 3: b = $urandom_range(1, 15);
                4:       b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er, ez, elat);
            run_op(a, b, s, lat, q, r, z);
            n_cmp += 4;
            if (lat !== elat) begin n_fail++; $display("FAIL rand_latency a=%h b=%h s=%b got=%0d exp=%0d", a, b, s, lat, elat); end
            if (q !== eq)     begin n_fail++; $display("FAIL rand_quotient a=%h b=%h s=%b got=%h exp=%h", a, b, s, q, eq); end
            if (r !== er)     begin n_fail++; $display("FAIL rand_remainder a=%h b=%h s=%b got=%h exp=%h", a, b, s, r, er); end
            if (z !== ez)     begin n_fail++; $display("FAIL rand_dbz a=%h b=%h s=%b got=%b exp=%b", a, b, s, z, ez); end
            @(negedge CLK);
            n_cmp += 2;
            if (done !== 1'b0) begin n_fail++; $display("FAIL rand_done_pulse got=%b exp=0", done); end
            if (quotient !== eq) begin n_fail++; $display("FAIL rand_hold got=%h exp=%h", quotient, eq); end
        end
    endtask

    initial begin
        RST = 1'b0; start = 1'b0; signed_op = 1'b0;
        Operand1 = '0; Operand2 = '0;
        repeat (3) @(posedge CLK);
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
`ifdef RADIX2_DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
